// File: rtl/cp0_ctrl_p_pkg.sv
// CP0 register numbers, exception type/code encodings, field positions and vector constants.
// Shared by the CP0 top, its timer and the testbench; holds no state.
package cp0_ctrl_p_pkg;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

  localparam logic [31:0] EXC_TYPE_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_TYPE_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_TYPE_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_TYPE_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_TYPE_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_TYPE_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_TYPE_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000e;

  localparam logic [4:0] EXC_CODE_INT  = 5'd0;
  localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
  localparam logic [4:0] EXC_CODE_ADES = 5'd5;
  localparam logic [4:0] EXC_CODE_SYS  = 5'd8;
  localparam logic [4:0] EXC_CODE_BP   = 5'd9;
  localparam logic [4:0] EXC_CODE_RI   = 5'd10;
  localparam logic [4:0] EXC_CODE_OV   = 5'd12;

  localparam int ST_IE_BIT  = 0;
  localparam int ST_EXL_BIT = 1;
  localparam int ST_BEV_BIT = 22;
  localparam int CA_BD_BIT  = 31;
  localparam int CA_TI_BIT  = 30;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] VEC_BEV      = 32'hBFC0_0380;
  localparam logic [31:0] VEC_NORMAL   = 32'h8000_0180;

  typedef struct packed {
    logic       known;
    logic       eret;
    logic       badv;
    logic [4:0] code;
  } exc_dec_t;

  function automatic exc_dec_t exc_decode(input logic [31:0] t);
    exc_dec_t d;
    d = '0;
    d.known = 1'b1;
    case (t)
      EXC_TYPE_INT:  d.code = EXC_CODE_INT;
      EXC_TYPE_ADEL: begin d.code = EXC_CODE_ADEL; d.badv = 1'b1; end
      EXC_TYPE_ADES: begin d.code = EXC_CODE_ADES; d.badv = 1'b1; end
      EXC_TYPE_SYS:  d.code = EXC_CODE_SYS;
      EXC_TYPE_BP:   d.code = EXC_CODE_BP;
      EXC_TYPE_RI:   d.code = EXC_CODE_RI;
      EXC_TYPE_OV:   d.code = EXC_CODE_OV;
      EXC_TYPE_ERET: d.eret = 1'b1;
      default:       d.known = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_ctrl_p_if.sv
// Pipeline <-> CP0 bundle: WB commit controls, mtc0/mfc0 access and CP0 state outputs.
// master = pipeline side, slave = CP0 side; no handshake, commits are single-cycle strobes.
interface cp0_ctrl_p_if;
  logic        stall;
  logic        exc_en;
  logic [31:0] except_type;
  logic [31:0] exc_pc;
  logic        exc_in_ds;
  logic [31:0] exc_badvaddr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        int_req;
  logic [31:0] exc_vector;

  modport master (
    output stall, exc_en, except_type, exc_pc, exc_in_ds, exc_badvaddr,
    output we, waddr, wdata, raddr,
    input  rdata, status, cause, epc, int_req, exc_vector
  );

  modport slave (
    input  stall, exc_en, except_type, exc_pc, exc_in_ds, exc_badvaddr,
    input  we, waddr, wdata, raddr,
    output rdata, status, cause, epc, int_req, exc_vector
  );
endinterface

// File: rtl/cp0_ctrl_p_timer.sv
// Count/Compare timer: Count advances once per COUNT_DIV clocks, TI latches on Count==Compare.
// TI sets one cycle after the match and is sticky until Compare is rewritten; no backpressure.
module cp0_timer_p #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap = (presc == PW'(COUNT_DIV - 1));

  // A Count write restarts the prescaler so the new value holds for a full period.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc <= '0;
      count <= '0;
    end else if (count_we) begin
      presc <= '0;
      count <= wdata;
    end else begin
      presc <= wrap ? '0 : presc + 1'b1;
      if (wrap) count <= count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      compare <= '0;
      ti      <= 1'b0;
    end else if (compare_we) begin
      compare <= wdata;
      ti      <= 1'b0;
    end else if ((count == compare) && (compare != 32'd0)) begin
      ti      <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_ctrl_p.sv
// CP0 at MEM/WB: Status/Cause/EPC/BadVAddr/timer state, exception entry, ERET, mfc0 read mux.
// Commits take effect at the next edge; int_req is registered; stall blocks commits, no backpressure.
module cp0_ctrl_p
  import cp0_ctrl_p_pkg::*;
#(
  parameter int          EXT_INT_W  = 6,
  parameter int          COUNT_DIV  = 2,
  parameter int          TIMER_IP   = 7,
  parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [EXT_INT_W-1:0] ext_int,
  cp0_ctrl_p_if.slave          bus
);
  exc_dec_t    dec;
  logic        exc_commit, exc_take, eret_take, wr_ok;
  logic        wr_status, wr_cause, wr_epc, wr_count, wr_compare;

  logic        ie, exl;
  logic [7:0]  im;
  logic        bd;
  logic [4:0]  exccode;
  logic [7:2]  ip_hw;
  logic [1:0]  ip_sw;
  logic [7:2]  ip_next;
  logic [31:0] epc_q, badvaddr;
  logic        int_req_q;
  logic [31:0] count, compare;
  logic        ti;
  logic [31:0] rd_mux;

  assign dec        = exc_decode(bus.except_type);
  assign exc_commit = bus.exc_en & ~bus.stall;
  assign exc_take   = exc_commit & dec.known & ~dec.eret;
  assign eret_take  = exc_commit & dec.known & dec.eret;
  // Any exception/ERET strobe in the slot drops a concurrent mtc0.
  assign wr_ok      = bus.we & ~bus.stall & ~bus.exc_en;
  assign wr_status  = wr_ok && (bus.waddr == CP0_REG_STATUS);
  assign wr_cause   = wr_ok && (bus.waddr == CP0_REG_CAUSE);
  assign wr_epc     = wr_ok && (bus.waddr == CP0_REG_EPC);
  assign wr_count   = wr_ok && (bus.waddr == CP0_REG_COUNT);
  assign wr_compare = wr_ok && (bus.waddr == CP0_REG_COMPARE);

  cp0_timer_p #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (bus.wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_comb begin
    ip_next = '0;
    for (int i = 0; i < EXT_INT_W; i++) ip_next[2+i] = ext_int[i];
    ip_next[TIMER_IP] = ip_next[TIMER_IP] | ti;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ie  <= 1'b0;
      exl <= 1'b0;
      im  <= '0;
    end else begin
      if (exc_take)       exl <= 1'b1;
      else if (eret_take) exl <= 1'b0;
      else if (wr_status) exl <= bus.wdata[ST_EXL_BIT];
      if (wr_status) begin
        ie <= bus.wdata[ST_IE_BIT];
        im <= bus.wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bd       <= 1'b0;
      exccode  <= '0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      epc_q    <= '0;
      badvaddr <= '0;
      int_req_q <= 1'b0;
    end else begin
      if (!bus.stall) ip_hw <= ip_next;
      int_req_q <= ie & ~exl & (|({ip_hw, ip_sw} & im));
      if (exc_take) begin
        exccode <= dec.code;
        // Nested entry keeps the original return point.
        if (!exl) begin
          bd    <= bus.exc_in_ds;
          epc_q <= bus.exc_in_ds ? bus.exc_pc - 32'd4 : bus.exc_pc;
        end
        if (dec.badv) badvaddr <= bus.exc_badvaddr;
      end
      if (wr_cause) ip_sw <= bus.wdata[9:8];
      if (wr_epc)   epc_q <= bus.wdata;
    end
  end

  assign bus.status     = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
  assign bus.cause      = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exccode, 2'b0};
  assign bus.epc        = epc_q;
  assign bus.int_req    = int_req_q;
  assign bus.exc_vector = bus.status[ST_BEV_BIT] ? VEC_BEV : VEC_NORMAL;

  always_comb begin
    rd_mux = '0;
    case (bus.raddr)
      CP0_REG_BADVADDR: rd_mux = badvaddr;
      CP0_REG_COUNT:    rd_mux = count;
      CP0_REG_COMPARE:  rd_mux = compare;
      CP0_REG_STATUS:   rd_mux = bus.status;
      CP0_REG_CAUSE:    rd_mux = bus.cause;
      CP0_REG_EPC:      rd_mux = epc_q;
      CP0_REG_PRID:     rd_mux = PRID_VAL;
      CP0_REG_CONFIG:   rd_mux = CONFIG_VAL;
      default:          rd_mux = '0;
    endcase
  end

  assign bus.rdata = resetn ? rd_mux : 32'd0;
endmodule

// File: tb/tb_cp0_ctrl_p.sv
// Directed bench for cp0_ctrl_p (COUNT_DIV=4): stimulus queues expected values, a negedge monitor compares.
module tb_cp0_ctrl_p;
  import cp0_ctrl_p_pkg::*;

  localparam int K_RD = 0, K_ST = 1, K_CA = 2, K_EPC = 3, K_IRQ = 4, K_VEC = 5;
  localparam logic [31:0] PRID = 32'h004c_0102;
  localparam logic [31:0] CFG  = 32'h0000_8000;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] ext_int = 6'h0;
  int         n_chk = 0;
  int         n_pass = 0;
  exp_t       sbq[$];

  cp0_ctrl_p_if bus();

  cp0_ctrl_p #(
    .EXT_INT_W(6), .COUNT_DIV(4), .TIMER_IP(7), .PRID_VAL(PRID), .CONFIG_VAL(CFG)
  ) dut (
    .clk(clk), .resetn(resetn), .ext_int(ext_int), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_RD:    act = bus.rdata;
        K_ST:    act = bus.status;
        K_CA:    act = bus.cause;
        K_EPC:   act = bus.epc;
        K_IRQ:   act = {31'b0, bus.int_req};
        default: act = bus.exc_vector;
      endcase
      n_chk++;
      if (act === e.val) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", e.name, act, e.val);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] v, input string name);
    bus.raddr = a;
    expect_val(K_RD, v, name);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    step();
    bus.we = 1'b0;
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                     input logic [31:0] bv);
    bus.exc_en = 1'b1;
    bus.except_type = t;
    bus.exc_pc = pc;
    bus.exc_in_ds = ds;
    bus.exc_badvaddr = bv;
    step();
    bus.exc_en = 1'b0;
  endtask

  initial begin
    bus.stall = 1'b0; bus.exc_en = 1'b0; bus.except_type = '0; bus.exc_pc = '0;
    bus.exc_in_ds = 1'b0; bus.exc_badvaddr = '0; bus.we = 1'b0; bus.waddr = '0;
    bus.wdata = '0; bus.raddr = '0;
    step(2);
    n_chk++;
    if (bus.status === 32'h0040_0000) n_pass++;
    else $display("FAIL direct_reset_status: got %08h", bus.status);
    n_chk++;
    if (bus.cause === 32'h0) n_pass++;
    else $display("FAIL direct_reset_cause: got %08h", bus.cause);
    n_chk++;
    if (bus.epc === 32'h0) n_pass++;
    else $display("FAIL direct_reset_epc: got %08h", bus.epc);
    n_chk++;
    if (bus.int_req === 1'b0) n_pass++;
    else $display("FAIL direct_reset_irq: got %b", bus.int_req);
    n_chk++;
    if (bus.exc_vector === 32'hBFC0_0380) n_pass++;
    else $display("FAIL direct_reset_vector: got %08h", bus.exc_vector);
    expect_val(K_ST, 32'h0040_0000, "reset_status");
    expect_val(K_CA, 32'h0, "reset_cause");
    expect_val(K_EPC, 32'h0, "reset_epc");
    expect_val(K_IRQ, 32'h0, "reset_irq");
    expect_val(K_VEC, 32'hBFC0_0380, "reset_vector");
    rd(CP0_REG_STATUS, 32'h0, "rdata_in_reset");
    step();

    resetn = 1'b1;
    mtc0(CP0_REG_COMPARE, 32'd3);
    step(10);
    rd(CP0_REG_COUNT, 32'd2, "count_at_11");
    step();
    rd(CP0_REG_COUNT, 32'd3, "count_at_12");
    expect_val(K_CA, 32'h0, "ti_not_yet");
    step();
    expect_val(K_CA, 32'h4000_0000, "ti_set");
    step();
    expect_val(K_CA, 32'h4000_8000, "ip7_timer");
    rd(CP0_REG_COMPARE, 32'd3, "compare_rd");
    mtc0(CP0_REG_COMPARE, 32'd10);
    expect_val(K_CA, 32'h0000_8000, "ti_cleared");
    rd(CP0_REG_COMPARE, 32'd10, "compare_rewrite");
    step();
    expect_val(K_CA, 32'h0, "ip7_clear");
    mtc0(CP0_REG_COUNT, 32'd100);
    rd(CP0_REG_COUNT, 32'd100, "count_load");
    step(3);
    rd(CP0_REG_COUNT, 32'd100, "presc_cleared");
    step();
    rd(CP0_REG_COUNT, 32'd101, "count_after_load");
    mtc0(CP0_REG_COMPARE, 32'd0);

    mtc0(CP0_REG_STATUS, 32'h0000_8401);
    expect_val(K_ST, 32'h0040_8401, "status_write");
    ext_int = 6'h01;
    step();
    expect_val(K_CA, 32'h0000_0400, "ip2_sampled");
    expect_val(K_IRQ, 32'h0, "irq_latency");
    step();
    expect_val(K_IRQ, 32'h1, "irq_set");
    bus.stall = 1'b1; ext_int = 6'h00;
    bus.we = 1'b1; bus.waddr = CP0_REG_EPC; bus.wdata = 32'h55;
    step();
    bus.we = 1'b0; bus.stall = 1'b0;
    expect_val(K_CA, 32'h0000_0400, "ip_hold_stall");
    expect_val(K_EPC, 32'h0, "mtc0_stalled");
    step();
    expect_val(K_CA, 32'h0, "ip2_drop");
    expect_val(K_IRQ, 32'h1, "irq_lags");
    step();
    expect_val(K_IRQ, 32'h0, "irq_clear");

    exc(EXC_TYPE_ADEL, 32'hBFC0_1004, 1'b1, 32'h3);
    expect_val(K_EPC, 32'hBFC0_1000, "adel_epc");
    expect_val(K_CA, 32'h8000_0010, "adel_cause");
    expect_val(K_ST, 32'h0040_8403, "adel_exl");
    expect_val(K_VEC, 32'hBFC0_0380, "adel_vector");
    rd(CP0_REG_BADVADDR, 32'h3, "adel_badvaddr");
    exc(EXC_TYPE_OV, 32'h8000_2000, 1'b0, 32'hdead);
    expect_val(K_EPC, 32'hBFC0_1000, "nested_epc");
    expect_val(K_CA, 32'h8000_0030, "nested_cause");
    rd(CP0_REG_BADVADDR, 32'h3, "ov_keeps_badv");
    exc(EXC_TYPE_ERET, 32'h0, 1'b0, 32'h0);
    expect_val(K_ST, 32'h0040_8401, "eret_exl");
    expect_val(K_EPC, 32'hBFC0_1000, "eret_epc");

    bus.we = 1'b1; bus.waddr = CP0_REG_EPC; bus.wdata = 32'h1234;
    exc(EXC_TYPE_SYS, 32'h8000_3000, 1'b0, 32'h0);
    bus.we = 1'b0;
    expect_val(K_EPC, 32'h8000_3000, "sys_beats_mtc0");
    expect_val(K_CA, 32'h0000_0020, "sys_cause");
    expect_val(K_ST, 32'h0040_8403, "sys_exl");
    exc(EXC_TYPE_ERET, 32'h0, 1'b0, 32'h0);
    expect_val(K_ST, 32'h0040_8401, "eret2_exl");
    mtc0(CP0_REG_EPC, 32'h1234);
    expect_val(K_EPC, 32'h1234, "mtc0_epc");
    exc(32'h0000_0003, 32'h9000_0000, 1'b1, 32'h77);
    expect_val(K_ST, 32'h0040_8401, "unk_status");
    expect_val(K_EPC, 32'h1234, "unk_epc");
    expect_val(K_CA, 32'h0000_0020, "unk_cause");
    rd(CP0_REG_BADVADDR, 32'h3, "unk_badv");
    mtc0(CP0_REG_STATUS, 32'hFFFF_FFFF);
    expect_val(K_ST, 32'h0040_FF03, "status_ro_bits");
    rd(CP0_REG_PRID, PRID, "prid");
    step();
    rd(CP0_REG_CONFIG, CFG, "config");
    expect_val(K_IRQ, 32'h0, "irq_masked_exl");
    step();
    rd(5'd3, 32'h0, "unmapped");

    ext_int = 6'h3f;
    mtc0(CP0_REG_STATUS, 32'h0000_FC01);
    step();
    expect_val(K_IRQ, 32'h1, "irq_all_ext");
    expect_val(K_CA, 32'h0000_FC20, "all_ext_cause");
    resetn = 1'b0;
    bus.we = 1'b1; bus.waddr = CP0_REG_EPC; bus.wdata = 32'habc;
    bus.exc_en = 1'b1; bus.except_type = EXC_TYPE_SYS;
    step();
    bus.we = 1'b0; bus.exc_en = 1'b0;
    expect_val(K_ST, 32'h0040_0000, "rst_status");
    expect_val(K_CA, 32'h0, "rst_cause");
    expect_val(K_EPC, 32'h0, "rst_epc");
    expect_val(K_IRQ, 32'h0, "rst_irq");
    rd(CP0_REG_STATUS, 32'h0, "rst_rdata");
    step();
    resetn = 1'b1; ext_int = 6'h0;
    step();
    rd(CP0_REG_COUNT, 32'h0, "rst_count");
    expect_val(K_CA, 32'h0, "rst_cause_after");
    step();
    rd(CP0_REG_COMPARE, 32'h0, "rst_compare");
    step();
    rd(CP0_REG_BADVADDR, 32'h0, "rst_badv");
    step(2);

    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_chk++;
      $display("FAIL %s: never compared, expected %08h", e.name, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
